run_sequencer: RTL and testbench

Job controller for the 16-bit multicycle computer. Accepts a program as a valid/ready word stream and writes it into the computer's memory through the load port (`addr_tb`/`data_tb`/`we_tb`). It then holds the CPU in reset for a fixed interval, runs it with `cpu_on` until `done` or a cycle-limit timeout, and captures `out_r` as the job result. It sits between the test/host side and the computer, replacing hand-driven load and run sequencing.

---
 rtl/run_seq_pkg.sv | 25 ++
 rtl/run_sequencer_if.sv | 25 ++
 rtl/run_sequencer_timer.sv | 32 +++
 rtl/run_sequencer.sv | 160 ++++++++++++++++
 tb/tb_run_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared definitions for the run_sequencer job controller.
//   - state_t      : FSM encoding (IDLE=0, LOAD=1, RST=2, RUN=3)
//   - defaults     : RST_CYCLES_DEFAULT, MAX_CYCLES_DEFAULT
//   - geometry     : memory depth 256, word width 16, derived address,
//                    length and cycle-counter widths
package run_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RST  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int RST_CYCLES_DEFAULT = 2;
    localparam int MAX_CYCLES_DEFAULT = 4096;

    localparam int MEM_DEPTH = 256;
    localparam int WORD_W    = 16;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    // One extra bit so a full-depth program length (256) is representable.
    localparam int LEN_W     = ADDR_W + 1;
    localparam int CNT_W     = 16;

endpackage

// File: rtl/run_sequencer_if.sv
// run_sequencer_if: valid/ready program word stream into the sequencer.
//   s_valid : word present (source -> sequencer)
//   s_data  : program word (source -> sequencer)
//   s_ready : sequencer accepts the word this cycle (sequencer -> source)
// modport master: the program source; modport slave: the sequencer.
interface run_sequencer_if;
    import run_seq_pkg::*;

    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/run_sequencer_timer.sv
// run_timer: clearable up-counter with a terminal-count compare.
//   clk, reset  : clock and synchronous active-high reset
//   clear       : force the count to 0 (takes priority over inc)
//   inc         : advance the count by one
//   tc_value    : terminal count to compare against
//   at_tc       : count currently equals tc_value
// The sequencer shares one instance between the CPU reset hold and the
// run timeout by switching tc_value with its state.
module run_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] tc_value,
    output logic         at_tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign at_tc = (count_reg == tc_value);

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: job controller for the 16-bit multicycle computer.
// Loads a program from a valid/ready stream into the computer's memory,
// holds the CPU in reset for RST_CYCLES, runs it until done or MAX_CYCLES,
// and captures out_r as the job result.
//   clk, reset        : clock, synchronous active-high reset
//   start, prog_len   : job request (IDLE only) and program length 0..256
//   s                 : program word stream (slave side)
//   addr_tb/data_tb/we_tb : memory load port to the computer
//   cpu_reset, cpu_on : computer control
//   cpu_out_r, cpu_done : computer status
//   busy, result, result_valid, timed_out : job status
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int RST_CYCLES = RST_CYCLES_DEFAULT,
    parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  prog_len,
    run_sequencer_if.slave    s,
    output logic [ADDR_W-1:0] addr_tb,
    output logic [WORD_W-1:0] data_tb,
    output logic              we_tb,
    output logic              cpu_reset,
    output logic              cpu_on,
    input  logic [WORD_W-1:0] cpu_out_r,
    input  logic              cpu_done,
    output logic              busy,
    output logic [WORD_W-1:0] result,
    output logic              result_valid,
    output logic              timed_out
);

    localparam logic [CNT_W-1:0] RST_TC = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_TC = CNT_W'(MAX_CYCLES - 1);

    state_t             state_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   wc_reg;
    logic [WORD_W-1:0]  result_reg;
    logic               result_valid_reg;
    logic               timed_out_reg;
    logic               s_ready_reg;
    logic               cpu_reset_reg;
    logic               cpu_on_reg;
    logic               busy_reg;

    logic               load_active;
    logic               beat;
    logic               last_beat;
    logic [CNT_W-1:0]   cc_tc_value;
    logic               cc_at_tc;
    logic               cc_clear;
    logic               cc_inc;

    // cc: RST hold counter, then RUN timeout counter. Cleared in IDLE and
    // again on the RST->RUN hand-over so RUN starts counting from 0.
    always_comb begin
        cc_tc_value = (state_reg == ST_RST) ? RST_TC : RUN_TC;
        cc_clear    = (state_reg == ST_IDLE) || ((state_reg == ST_RST) && cc_at_tc);
        cc_inc      = (state_reg == ST_RST) || (state_reg == ST_RUN);
    end

    run_timer #(.W(CNT_W)) u_cc (
        .clk      (clk),
        .reset    (reset),
        .clear    (cc_clear),
        .inc      (cc_inc),
        .tc_value (cc_tc_value),
        .at_tc    (cc_at_tc)
    );

    // Load port is a combinational pass-through of the stream while loading,
    // so a word is written in the same cycle it is accepted.
    assign load_active = (state_reg == ST_LOAD);
    assign beat        = load_active && s.s_valid;
    // len is never 0 in LOAD, so len-1 does not underflow; with len=256 the
    // last beat is at wc=255 and the address never wraps.
    assign last_beat   = beat && (wc_reg == (len_reg - LEN_W'(1)));

    assign we_tb   = beat;
    assign addr_tb = load_active ? wc_reg[ADDR_W-1:0] : '0;
    assign data_tb = load_active ? s.s_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            len_reg          <= '0;
            wc_reg           <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            timed_out_reg    <= 1'b0;
            s_ready_reg      <= 1'b0;
            cpu_reset_reg    <= 1'b1;
            cpu_on_reg       <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        len_reg          <= prog_len;
                        wc_reg           <= '0;
                        result_reg       <= '0;
                        result_valid_reg <= 1'b0;
                        timed_out_reg    <= 1'b0;
                        busy_reg         <= 1'b1;
                        if (prog_len != '0) begin
                            state_reg   <= ST_LOAD;
                            s_ready_reg <= 1'b1;
                        end else begin
                            state_reg   <= ST_RST;
                        end
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        wc_reg <= wc_reg + LEN_W'(1);
                    end
                    if (last_beat) begin
                        state_reg   <= ST_RST;
                        s_ready_reg <= 1'b0;
                    end
                end
                ST_RST: begin
                    if (cc_at_tc) begin
                        state_reg     <= ST_RUN;
                        cpu_reset_reg <= 1'b0;
                        cpu_on_reg    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // done and timeout in the same cycle: done wins.
                    if (cpu_done || cc_at_tc) begin
                        result_reg       <= cpu_out_r;
                        result_valid_reg <= 1'b1;
                        timed_out_reg    <= !cpu_done;
                        state_reg        <= ST_IDLE;
                        cpu_on_reg       <= 1'b0;
                        cpu_reset_reg    <= 1'b1;
                        busy_reg         <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.s_ready    = s_ready_reg;
    assign cpu_reset    = cpu_reset_reg;
    assign cpu_on       = cpu_on_reg;
    assign busy         = busy_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign timed_out    = timed_out_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scoreboard bench for run_sequencer (RST_CYCLES=2,
// MAX_CYCLES=16). Each job pushes its hand-computed memory writes,
// run-start cycle and result into queues; a negedge monitor pops and
// compares whenever the DUT writes, raises cpu_on or raises result_valid.
// Cycle numbers are relative to the cycle in which start is presented.
module tb_run_sequencer;
    import run_seq_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  prog_len = '0;
    logic [ADDR_W-1:0] addr_tb;
    logic [WORD_W-1:0] data_tb;
    logic              we_tb;
    logic              cpu_reset;
    logic              cpu_on;
    logic [WORD_W-1:0] cpu_out_r = '0;
    logic              cpu_done = 1'b0;
    logic              busy;
    logic [WORD_W-1:0] result;
    logic              result_valid;
    logic              timed_out;

    run_sequencer_if sif();

    run_sequencer #(.RST_CYCLES(2), .MAX_CYCLES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prog_len     (prog_len),
        .s            (sif),
        .addr_tb      (addr_tb),
        .data_tb      (data_tb),
        .we_tb        (we_tb),
        .cpu_reset    (cpu_reset),
        .cpu_on       (cpu_on),
        .cpu_out_r    (cpu_out_r),
        .cpu_done     (cpu_done),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .timed_out    (timed_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
        int          t;
    } wr_t;

    typedef struct packed {
        logic [15:0] r;
        logic        to;
        int          t;
    } res_t;

    wr_t  wr_q[$];
    int   on_q[$];
    res_t res_q[$];

    int cyc = 0;
    int job_start = 0;
    int done_after = 0;
    int on_n = 0;
    int n_vec = 0;
    int n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, got, exp, cyc - job_start);
        end
    endfunction

    // CPU model: asserts done in the done_after-th cycle of cpu_on.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cpu_on) on_n++;
            else on_n = 0;
            cpu_done = cpu_on && (done_after != 0) && (on_n == done_after);
        end
    end

    // Monitor: pops and compares on every DUT-presented event.
    logic prev_on = 1'b0;
    logic prev_rv = 1'b0;
    int   rel;
    wr_t  ew;
    int   eon;
    res_t er;
    always @(negedge clk) begin
        rel = cyc - job_start;
        if (we_tb === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", {8'h0, addr_tb, data_tb, rel}, 64'h0);
            end else begin
                ew = wr_q.pop_front();
                chk("write", {8'h0, addr_tb, data_tb, rel}, {8'h0, ew.a, ew.d, ew.t});
                $display("wr   t=%0d addr=%02h data=%04h", rel, addr_tb, data_tb);
            end
        end
        if (cpu_on === 1'b1 && !prev_on) begin
            if (on_q.size() == 0) begin
                chk("unexpected_run", 64'(rel), 64'h0);
            end else begin
                eon = on_q.pop_front();
                chk("run_start", {rel, cpu_reset, result_valid, timed_out, result},
                    {eon, 1'b0, 1'b0, 1'b0, 16'h0});
                $display("run  t=%0d", rel);
            end
        end
        if (result_valid === 1'b1 && !prev_rv) begin
            if (res_q.size() == 0) begin
                chk("unexpected_result", 64'(rel), 64'h0);
            end else begin
                er = res_q.pop_front();
                chk("result", {15'h0, result, timed_out, rel}, {15'h0, er.r, er.to, er.t});
                chk("end_ctl", {62'h0, cpu_on, cpu_reset}, 64'h1);
                $display("res  t=%0d result=%04h timed_out=%0b", rel, result, timed_out);
            end
        end
        prev_on = (cpu_on === 1'b1);
        prev_rv = (result_valid === 1'b1);
    end

    task automatic do_start(input int len);
        start = 1'b1;
        prog_len = LEN_W'(len);
        job_start = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d, output bit ok);
        ok = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_data = d;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (sif.s_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'(busy), 64'h0);
        #1;  // let the monitor finish this cycle before the queues are checked
    endtask

    task automatic job(input int len, input bit gap, input logic [15:0] base,
                       input logic [15:0] step, input int done_n, input logic [15:0] outv,
                       input int exp_on, input int exp_res, input bit exp_to,
                       input bit poke_start);
        bit ok;
        for (int i = 0; i < len; i++) begin
            wr_q.push_back('{a: 8'(i), d: base + 16'(i) * step, t: gap ? 1 + 2 * i : 1 + i});
        end
        on_q.push_back(exp_on);
        res_q.push_back('{r: outv, to: exp_to, t: exp_res});
        done_after = done_n;
        cpu_out_r = outv;
        do_start(len);
        for (int i = 0; i < len; i++) begin
            if (poke_start && i == 1) begin
                start = 1'b1;
                prog_len = '0;
            end
            push_word(base + 16'(i) * step, ok);
            start = 1'b0;
            if (!ok) chk("handshake_timeout", 64'(i), 64'hFFFF);
            if (gap && i < len - 1) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle(400);
        chk("writes_left", 64'(wr_q.size()), 64'h0);
        chk("runs_left", 64'(on_q.size()), 64'h0);
        chk("results_left", 64'(res_q.size()), 64'h0);
        done_after = 0;
        $display("job  len=%0d gap=%0b done_after=%0d ended", len, gap, done_n);
    endtask

    initial begin
        bit ok;
        sif.s_valid = 1'b1;       // held high through reset/IDLE: must not write
        sif.s_data = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_s_ready", 64'(sif.s_ready), 64'h0);
        chk("rst_we_tb", 64'(we_tb), 64'h0);
        chk("rst_addr_tb", 64'(addr_tb), 64'h0);
        chk("rst_data_tb", 64'(data_tb), 64'h0);
        chk("rst_cpu_on", 64'(cpu_on), 64'h0);
        chk("rst_cpu_reset", 64'(cpu_reset), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_result", 64'(result), 64'h0);
        chk("rst_result_valid", 64'(result_valid), 64'h0);
        chk("rst_timed_out", 64'(timed_out), 64'h0);
        @(posedge clk);
        #1;
        sif.s_valid = 1'b0;

        //   len gap base     step     done outv      on   res  to poke
        job(3,   0, 16'h1111, 16'h1111, 10, 16'hBEEF,  6,   16, 0, 0);
        job(4,   1, 16'h4000, 16'h0001, 10, 16'h1234, 10,   20, 0, 0);
        job(256, 0, 16'hA000, 16'h0001,  0, 16'h5A5A, 259, 275, 1, 0);
        job(0,   0, 16'h0000, 16'h0000,  0, 16'h0F0F,  3,   19, 1, 0);
        job(0,   0, 16'h0000, 16'h0000, 16, 16'hCAFE,  3,   19, 0, 0);

        // Abort: reset after 2 of 5 words.
        wr_q.push_back('{a: 8'h00, d: 16'h7000, t: 1});
        wr_q.push_back('{a: 8'h01, d: 16'h7001, t: 2});
        do_start(5);
        push_word(16'h7000, ok);
        push_word(16'h7001, ok);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_s_ready", 64'(sif.s_ready), 64'h0);
        chk("abort_cpu_reset", 64'(cpu_reset), 64'h1);
        chk("abort_result_valid", 64'(result_valid), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_writes_left", 64'(wr_q.size()), 64'h0);
        $display("job  abort after 2 words");

        // start pulse during LOAD must be ignored.
        job(3, 0, 16'h0101, 16'h0101, 10, 16'h600D, 6, 16, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
